barrett_reduce_pipe: RTL

BARRETT_REDUCE_PIPE -- requirements
Module: barrett_reduce_pipe

---
 rtl/barrett_pkg.sv | 28 ++
 rtl/barrett_cond_sub.sv | 27 ++
 rtl/barrett_reduce_pipe.sv | 91 +++++++++
 3 files changed

// File: rtl/barrett_pkg.sv
// Shared constants and elaboration helpers for the Barrett
// modular reduction pipeline.
package barrett_pkg;

  localparam int Q_967  = 967;
  localparam int K_10   = 10;
  localparam int Q_3329 = 3329;
  localparam int K_12   = 12;

  function automatic int clog2(input longint v);
    longint x;
    int     r;
    x = v - 1;
    r = 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int mu_of(input int q, input int k);
    longint n;
    n = longint'(1) << (2 * k);
    return int'(n / longint'(q));
  endfunction

endpackage

// File: rtl/barrett_cond_sub.sv
// Final Barrett correction: t2 < 3Q, so two conditional
// subtractions of Q always land in [0, Q).
module barrett_cond_sub
  import barrett_pkg::*;
#(
  parameter int K = 10
) (
  input  logic [K+1:0] t2_i,
  input  logic [K+1:0] q_i,
  output logic [K-1:0] r_o
);

  logic [K+1:0] s1;
  logic [K+1:0] s2;
  logic         unused_hi;

  always_comb begin
    s1 = t2_i;
    if (t2_i >= q_i) s1 = t2_i - q_i;
    s2 = s1;
    if (s1 >= q_i) s2 = s1 - q_i;
  end

  assign r_o       = s2[K-1:0];
  assign unused_hi = ^s2[K+1:K];

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Three-stage Barrett reduction of a 2K-bit operand mod Q
// with valid/ready flow control and a sideband tag.
module barrett_reduce_pipe
  import barrett_pkg::*;
#(
  parameter int Q     = Q_967,
  parameter int K     = K_10,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*K-1:0]   din_a,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     dout_r,
  output logic [TAG_W-1:0] out_tag
);

  localparam int MU  = mu_of(Q, K);
  localparam int W1  = 2 * K + 1;
  localparam int T2W = K + 2;

  // clog2(Q+1) == K holds exactly when 2**(K-1) <= Q < 2**K
  if (clog2(longint'(Q) + 1) != K || Q < 3 || (Q % 2) == 0)
  begin : g_bad_q
    $error("barrett_reduce_pipe: Q must be odd with 2**(K-1) <= Q < 2**K");
  end

  logic             adv;
  logic             s1_v_q, s2_v_q, s3_v_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q, s3_tag_q;
  logic [2*K-1:0]   s1_a_q;
  logic [W1-1:0]    s1_t1_q, t1_d;
  logic [W1-1:0]    prod_w, diff_w;
  logic [T2W-1:0]   s2_t2_q, t2_d;
  logic [K-1:0]     s3_r_q, r_d;
  logic             unused_bits;

  assign adv      = !s3_v_q || out_ready;
  assign in_ready = adv;

  assign t1_d   = W1'(din_a[2*K-1:K]) * W1'(MU);
  assign prod_w = W1'(s1_t1_q[W1-1:K]) * W1'(Q);
  assign diff_w = W1'(s1_a_q) - prod_w;
  // true difference is below 3Q, so its low K+2 bits are exact
  assign t2_d   = diff_w[T2W-1:0];

  assign unused_bits = ^{s1_t1_q[K-1:0], diff_w[W1-1:T2W]};

  barrett_cond_sub #(
    .K(K)
  ) u_cond_sub (
    .t2_i(s2_t2_q),
    .q_i (T2W'(Q)),
    .r_o (r_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s3_v_q   <= 1'b0;
      s1_tag_q <= '0;
      s2_tag_q <= '0;
      s3_tag_q <= '0;
      s1_a_q   <= '0;
      s1_t1_q  <= '0;
      s2_t2_q  <= '0;
      s3_r_q   <= '0;
    end else if (adv) begin
      s1_v_q   <= in_valid;
      s1_tag_q <= in_tag;
      s1_a_q   <= din_a;
      s1_t1_q  <= t1_d;
      s2_v_q   <= s1_v_q;
      s2_tag_q <= s1_tag_q;
      s2_t2_q  <= t2_d;
      s3_v_q   <= s2_v_q;
      s3_tag_q <= s2_tag_q;
      s3_r_q   <= r_d;
    end
  end

  assign out_valid = s3_v_q;
  assign dout_r    = s3_r_q;
  assign out_tag   = s3_tag_q;

endmodule
